mem_stage_pipe: RTL and testbench
=================================

Name: mem_stage_pipe

Overview:
Parametrised Y86-64 memory-access stage with an embedded data RAM. It sits between execute and write-back and uses valid/ready handshakes on both sides. It decodes icode to select address, write data and direction, and takes a configurable multi-cycle access latency. It flags out-of-range or misaligned accesses and holds its result until write-back accepts it.

Parameters:
DATA_W, 64, data word width in bits; must be a multiple of 8
MEM_BYTES, 8192, RAM capacity in bytes; must be a multiple of DATA_W/8
LATENCY, 2, cycles from accept to result valid for memory ops; must be at least 1
ALIGN_CHECK, 1, 1 = misaligned address is an error; 0 = low address bits are ignored and the access is truncated to a word boundary

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  1  upstream instruction valid
in_ready_o  out  1  stage can accept
icode_i  in  4  instruction code (define.v encodings)
valA_i  in  DATA_W  register operand A
valE_i  in  DATA_W  ALU result / effective address
valP_i  in  DATA_W  next PC
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts
icode_o  out  4  registered icode
valE_o  out  DATA_W  registered valE_i, passed through
valM_o  out  DATA_W  read data; 0 for non-reads and on error
dmem_error_o  out  1  access error, qualified by out_valid_o
busy_o  out  1  high in WAIT state

Behaviour:
- Decode (at accept):
  - write = IRMMOVQ | ICALL | IPUSHQ
  - read = IMRMOVQ | IRET | IPOPQ
  - addr = valE_i for IRMMOVQ, IMRMOVQ, ICALL, IPUSHQ; valA_i for IRET, IPOPQ
  - wdata = valA_i for IRMMOVQ, IPUSHQ; valP_i for ICALL
- RAM layout: byte-addressed, little-endian words of DATA_W/8 bytes; word index = addr / (DATA_W/8).
- Error: memory op with addr > MEM_BYTES − DATA_W/8 (unsigned compare, no wrap), or ALIGN_CHECK=1 and addr mod (DATA_W/8) ≠ 0.
  - On error: no RAM write; valM_o = 0; dmem_error_o = 1.
- Operand capture: all inputs are captured at the accept edge. Later input changes have no effect.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: in_ready_o = 1. On accept:
    - non-memory op or error op → HOLD
    - memory op with LATENCY = 1 → HOLD
    - otherwise → WAIT with counter = LATENCY − 1
  - WAIT: counter decrements each cycle. On the cycle counter = 1 → HOLD.
  - Commit: the RAM write, or the read into valM_o, happens on the edge entering HOLD.
  - Latency: non-memory and error ops reach out_valid_o 1 cycle after accept; good memory ops after LATENCY cycles.
  - HOLD: out_valid_o = 1, and icode_o, valE_o, valM_o, dmem_error_o stay stable until out_ready_i = 1.
    - On handshake → IDLE.
    - in_ready_o = out_ready_i in HOLD. A simultaneous new accept goes straight to its next state, giving back-to-back ops with no bubble.
- Read-after-write: a read following a write to the same address returns the newly written data.
- Reset:
  - state → IDLE; out_valid_o, busy_o, dmem_error_o = 0; icode_o, valE_o, valM_o = 0
  - RAM contents are not reset.
  - Reset has priority over everything. A write whose commit edge coincides with rst_i is dropped. An op in WAIT is abandoned with no write.
- Unknown icode: treated as a non-memory op with no error.

Test Plan:
- Reset, then IRMMOVQ valE=0x100, valA=0xDEADBEEF01234567; then IMRMOVQ valE=0x100 → write result out_valid 2 cycles after accept with error=0; read returns valM=0xDEADBEEF01234567 2 cycles after its accept.
- ICALL valE=0x1F8, valP=0x42; then IRET valA=0x1F8 → RAM word 0x1F8 = 0x42 and IRET valM=0x42; IPUSHQ/IPOPQ pair at 0x1F0 with valA=0x7 → IPOPQ valM=0x7.
- IMRMOVQ valE=0x2000 (MEM_BYTES=8192), and separately valE=0x103 → out_valid 1 cycle after accept, dmem_error=1, valM=0, RAM unchanged; with ALIGN_CHECK=0 the 0x103 access reads word 0x100 with error=0.
- Hold out_ready_i=0 for 5 cycles after a read → out_valid stays 1 with outputs stable and in_ready_o=0; with out_ready_i=1 in HOLD and a new op presented, it is accepted on the same edge with no bubble.
- IOPQ (icode 6) valE=0x55 → out_valid after 1 cycle, valE_o=0x55, valM=0, error=0, busy_o never high.
- Assert rst_i during WAIT of IRMMOVQ addr 0x80 → outputs cleared next edge; a later read of 0x80 returns its prior contents.

Source files
------------

// File: rtl/mem_stage_pipe_if.sv
// Handshake and data bundle linking execute, the memory stage and write-back.
interface mem_stage_pipe_if #(
  parameter int DATA_W = 64
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [3:0]        icode_i;
  logic [DATA_W-1:0] valA_i;
  logic [DATA_W-1:0] valE_i;
  logic [DATA_W-1:0] valP_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [3:0]        icode_o;
  logic [DATA_W-1:0] valE_o;
  logic [DATA_W-1:0] valM_o;
  logic              dmem_error_o;
  logic              busy_o;

  // Surrounding pipeline: execute drives the request, write-back drives ready.
  modport master (
    output in_valid_i, icode_i, valA_i, valE_i, valP_i, out_ready_i,
    input  in_ready_o, out_valid_o, icode_o, valE_o, valM_o, dmem_error_o, busy_o
  );

  // The memory stage itself.
  modport slave (
    input  in_valid_i, icode_i, valA_i, valE_i, valP_i, out_ready_i,
    output in_ready_o, out_valid_o, icode_o, valE_o, valM_o, dmem_error_o, busy_o
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// Y86-64 memory-access stage with embedded word-organised data RAM.
// One instruction in flight: accept in IDLE (or HOLD on handshake), optional
// WAIT for the access latency, then HOLD until write-back takes the result.
module mem_stage_pipe #(
  parameter int DATA_W      = 64,
  parameter int MEM_BYTES   = 8192,
  parameter int LATENCY     = 2,
  parameter int ALIGN_CHECK = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  mem_stage_pipe_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int WORDS = MEM_BYTES / BYTES;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  // Highest legal byte address of a full word; compared unsigned, no wrap.
  localparam logic [DATA_W-1:0] ADDR_MAX = DATA_W'(MEM_BYTES - BYTES);
  localparam logic [DATA_W-1:0] OFF_MASK = DATA_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  function automatic logic is_write(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
  endfunction

  function automatic logic is_read(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
  endfunction

  // Stack pops address through valA (old %rsp); everything else uses valE.
  function automatic logic [DATA_W-1:0] sel_addr(input logic [3:0]        icode,
                                                 input logic [DATA_W-1:0] val_a,
                                                 input logic [DATA_W-1:0] val_e);
    return ((icode == IRET) || (icode == IPOPQ)) ? val_a : val_e;
  endfunction

  // A call pushes the return address; other writes store register A.
  function automatic logic [DATA_W-1:0] sel_wdata(input logic [3:0]        icode,
                                                  input logic [DATA_W-1:0] val_a,
                                                  input logic [DATA_W-1:0] val_p);
    return (icode == ICALL) ? val_p : val_a;
  endfunction

  function automatic logic addr_error(input logic [DATA_W-1:0] addr);
    logic misaligned;
    misaligned = (ALIGN_CHECK != 0) && ((addr & OFF_MASK) != '0);
    return (addr > ADDR_MAX) || misaligned;
  endfunction

  // Byte address to word index; low offset bits dropped (word-truncated).
  function automatic logic [IDX_W-1:0] word_index(input logic [DATA_W-1:0] addr);
    return IDX_W'(addr >> OFF_W);
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               in_ready;
  logic               out_valid;
  logic               busy;
  logic               accept;
  logic               acc_to_hold;
  logic               commit;

  logic               dec_wr;
  logic               dec_rd;
  logic               dec_err;
  logic [DATA_W-1:0]  dec_addr;
  logic [DATA_W-1:0]  dec_wdata;

  logic [3:0]         icode_p0;
  logic [DATA_W-1:0]  vale_p0;
  logic [DATA_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  wdata_p0;
  logic               wr_p0;
  logic               rd_p0;

  logic [3:0]         cmt_icode;
  logic [DATA_W-1:0]  cmt_vale;
  logic [DATA_W-1:0]  cmt_addr;
  logic [DATA_W-1:0]  cmt_wdata;
  logic               cmt_wr;
  logic               cmt_rd;
  logic               cmt_err;
  logic [IDX_W-1:0]   cmt_idx;

  logic [3:0]         icode_p1;
  logic [DATA_W-1:0]  vale_p1;
  logic [DATA_W-1:0]  valm_p1;
  logic               err_p1;

  logic [DATA_W-1:0]  mem [WORDS];

  // Decode the live request; only meaningful on the accept edge.
  always_comb begin
    dec_wr    = is_write(bus.icode_i);
    dec_rd    = is_read(bus.icode_i);
    dec_addr  = sel_addr(bus.icode_i, bus.valA_i, bus.valE_i);
    dec_wdata = sel_wdata(bus.icode_i, bus.valA_i, bus.valP_i);
    dec_err   = (dec_wr || dec_rd) && addr_error(dec_addr);
  end

  // Non-memory ops, faulting ops and single-cycle memories skip WAIT.
  assign acc_to_hold = !(dec_wr || dec_rd) || dec_err || (LATENCY == 1);
  assign accept      = bus.in_valid_i && in_ready;

  // FSM state and latency counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; commit marks the edge that enters HOLD with a new result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          if (acc_to_hold) begin
            state_d = S_HOLD;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else if ((state_q == S_HOLD) && bus.out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; HOLD passes ready through so a new op can enter with no bubble.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_WAIT: busy = 1'b1;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready_i;
      end
      default: ;
    endcase
  end

  // --- p0: operands captured on accept, used when the access finishes in WAIT
  always_ff @(posedge clk_i) begin
    if (accept) begin
      icode_p0 <= bus.icode_i;
      vale_p0  <= bus.valE_i;
      addr_p0  <= dec_addr;
      wdata_p0 <= dec_wdata;
      wr_p0    <= dec_wr;
      rd_p0    <= dec_rd;
    end
  end

  // Commit source: the live request when it skips WAIT, otherwise the capture.
  // Ops that reach WAIT were already checked, so their error flag is clear.
  always_comb begin
    if (accept) begin
      cmt_icode = bus.icode_i;
      cmt_vale  = bus.valE_i;
      cmt_addr  = dec_addr;
      cmt_wdata = dec_wdata;
      cmt_wr    = dec_wr;
      cmt_rd    = dec_rd;
      cmt_err   = dec_err;
    end else begin
      cmt_icode = icode_p0;
      cmt_vale  = vale_p0;
      cmt_addr  = addr_p0;
      cmt_wdata = wdata_p0;
      cmt_wr    = wr_p0;
      cmt_rd    = rd_p0;
      cmt_err   = 1'b0;
    end
    cmt_idx = word_index(cmt_addr);
  end

  // --- p1: result registers presented to write-back, frozen through HOLD
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      icode_p1 <= '0;
      vale_p1  <= '0;
      valm_p1  <= '0;
      err_p1   <= 1'b0;
    end else if (commit) begin
      icode_p1 <= cmt_icode;
      vale_p1  <= cmt_vale;
      valm_p1  <= (cmt_rd && !cmt_err) ? mem[cmt_idx] : '0;
      err_p1   <= cmt_err;
    end
  end

  // RAM write on the commit edge; reset on that edge drops the store.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && cmt_wr && !cmt_err) begin
      mem[cmt_idx] <= cmt_wdata;
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid;
  assign bus.busy_o       = busy;
  assign bus.icode_o      = icode_p1;
  assign bus.valE_o       = vale_p1;
  assign bus.valM_o       = valm_p1;
  assign bus.dmem_error_o = err_p1;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: two instances (aligned, latency 2; unaligned-
// truncating, latency 3) driven by directed steps then random ops, checked
// against a word-array reference model built from the instruction rules.
module tb_mem_stage_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_pipe_if #(.DATA_W(64)) ia ();
  mem_stage_pipe_if #(.DATA_W(64)) ib ();

  mem_stage_pipe #(.DATA_W(64), .MEM_BYTES(8192), .LATENCY(2), .ALIGN_CHECK(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ia));
  mem_stage_pipe #(.DATA_W(64), .MEM_BYTES(8192), .LATENCY(3), .ALIGN_CHECK(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ib));

  int          sel;
  logic        in_valid, out_ready;
  logic [3:0]  icode;
  logic [63:0] val_a, val_e, val_p;

  assign ia.in_valid_i  = in_valid && (sel == 0);
  assign ib.in_valid_i  = in_valid && (sel == 1);
  assign ia.icode_i     = icode;
  assign ib.icode_i     = icode;
  assign ia.valA_i      = val_a;
  assign ib.valA_i      = val_a;
  assign ia.valE_i      = val_e;
  assign ib.valE_i      = val_e;
  assign ia.valP_i      = val_p;
  assign ib.valP_i      = val_p;
  assign ia.out_ready_i = out_ready;
  assign ib.out_ready_i = out_ready;

  logic        o_ready, o_valid, o_busy, o_err;
  logic [3:0]  o_icode;
  logic [63:0] o_vale, o_valm;
  assign o_ready = (sel == 1) ? ib.in_ready_o   : ia.in_ready_o;
  assign o_valid = (sel == 1) ? ib.out_valid_o  : ia.out_valid_o;
  assign o_busy  = (sel == 1) ? ib.busy_o       : ia.busy_o;
  assign o_err   = (sel == 1) ? ib.dmem_error_o : ia.dmem_error_o;
  assign o_icode = (sel == 1) ? ib.icode_o      : ia.icode_o;
  assign o_vale  = (sel == 1) ? ib.valE_o       : ia.valE_o;
  assign o_valm  = (sel == 1) ? ib.valM_o       : ia.valM_o;

  int          lat_of   [2] = '{2, 3};
  bit          align_of [2] = '{1'b1, 1'b0};
  logic [63:0] ref_mem  [2][1024];
  bit          known    [2][1024];
  int          checks = 0;
  int          errors = 0;
  bit          in_hold = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Present one op (from a negedge), check its result, stay in HOLD for 'hold'
  // extra cycles. b2b raises out_ready together with in_valid.
  task automatic do_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p, input int hold, input bit b2b);
    bit          wr, rd, mem, err, chk_m;
    logic [63:0] addr, wdata, exp_m;
    int          idx, lat, n;
    wr    = ic inside {4'h4, 4'h8, 4'hA};
    rd    = ic inside {4'h5, 4'h9, 4'hB};
    mem   = wr || rd;
    addr  = (ic == 4'h9 || ic == 4'hB) ? a : e;
    wdata = (ic == 4'h8) ? p : a;
    err   = mem && ((addr > 64'd8184) || (align_of[sel] && ((addr % 64'd8) != 64'd0)));
    lat   = (mem && !err) ? lat_of[sel] : 1;
    idx   = 0;
    if (mem && !err) idx = int'(addr / 64'd8);
    exp_m = 64'd0;
    chk_m = 1'b1;
    if (rd && !err) begin
      if (known[sel][idx]) exp_m = ref_mem[sel][idx];
      else chk_m = 1'b0;
    end
    if (wr && !err) begin
      ref_mem[sel][idx] = wdata;
      known[sel][idx]   = 1'b1;
    end
    icode = ic; val_a = a; val_e = e; val_p = p;
    in_valid = 1'b1;
    if (b2b) out_ready = 1'b1;
    #1;
    chk("in_ready", o_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    icode = 4'($urandom()); val_a = rnd64(); val_e = rnd64(); val_p = rnd64();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("busy", o_busy, (n < lat));
    end while (!o_valid && n < 12);
    chk("latency", n, lat);
    chk("icode_o", o_icode, ic);
    chk("valE_o", o_vale, e);
    if (chk_m) chk("valM_o", o_valm, exp_m);
    chk("dmem_error", o_err, err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", o_valid, 1'b1);
      chk("hold_in_ready", o_ready, 1'b0);
      chk("hold_icode", o_icode, ic);
      chk("hold_valE", o_vale, e);
      if (chk_m) chk("hold_valM", o_valm, exp_m);
      chk("hold_err", o_err, err);
    end
    in_hold = 1'b1;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("drained_valid", o_valid, 1'b0);
    in_hold = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, o_valid, 1'b0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);
    chk({tag, "_icode"}, o_icode, 4'h0);
    chk({tag, "_valE"}, o_vale, 64'd0);
    chk({tag, "_valM"}, o_valm, 64'd0);
    chk({tag, "_in_ready"}, o_ready, 1'b1);
  endtask

  task automatic random_ops(input int count);
    logic [3:0]  ic;
    logic [63:0] addr, a, e;
    logic [3:0]  mem_codes [6] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    int          mode;
    bit          b2b;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 9) < 7) ic = mem_codes[$urandom_range(0, 5)];
      else ic = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 9);
      case (mode)
        0:       addr = 64'h2000 + 64'(8 * $urandom_range(0, 4));
        1:       addr = 64'(8 * $urandom_range(0, 31) + $urandom_range(1, 7));
        2:       addr = 64'h1FF8;
        3:       addr = 64'hFFFF_FFFF_FFFF_FFF8;
        default: addr = 64'(8 * $urandom_range(0, 31));
      endcase
      a = rnd64(); e = rnd64();
      if (ic == 4'h9 || ic == 4'hB) a = addr;
      else e = addr;
      b2b = in_hold && ($urandom_range(0, 1) == 1);
      if (in_hold && !b2b) release_op();
      do_op(ic, a, e, rnd64(), $urandom_range(0, 2), b2b);
    end
    release_op();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; in_valid = 1'b0; out_ready = 1'b0;
    icode = 4'h0; val_a = 64'd0; val_e = 64'd0; val_p = 64'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("rst_a");
    sel = 1; #1;
    check_cleared("rst_b");
    sel = 0;
    rst = 1'b0;

    // Store then load at 0x100
    do_op(4'h4, 64'hDEADBEEF01234567, 64'h100, 64'd0, 0, 0); release_op();
    do_op(4'h5, 64'd0, 64'h100, 64'd0, 0, 0); release_op();
    // Call/return and push/pop through the stack
    do_op(4'h8, rnd64(), 64'h1F8, 64'h42, 0, 0); release_op();
    do_op(4'h9, 64'h1F8, rnd64(), rnd64(), 0, 0); release_op();
    do_op(4'hA, 64'h7, 64'h1F0, rnd64(), 0, 0); release_op();
    do_op(4'hB, 64'h1F0, rnd64(), rnd64(), 0, 0); release_op();
    // Out-of-range and misaligned accesses
    do_op(4'h5, 64'd0, 64'h2000, 64'd0, 0, 0); release_op();
    do_op(4'h5, 64'd0, 64'h103, 64'd0, 0, 0); release_op();
    do_op(4'h4, 64'h1111, 64'h104, 64'd0, 0, 0); release_op();
    do_op(4'h5, 64'd0, 64'h100, 64'd0, 0, 0); release_op();
    do_op(4'h4, 64'hA5A5, 64'h0, 64'd0, 0, 0); release_op();
    do_op(4'h4, 64'h5A5A, 64'h2000, 64'd0, 0, 0); release_op();
    do_op(4'h5, 64'd0, 64'h0, 64'd0, 0, 0); release_op();
    do_op(4'h4, 64'h1FF8_CAFE, 64'h1FF8, 64'd0, 0, 0); release_op();
    do_op(4'h5, 64'd0, 64'h1FF8, 64'd0, 0, 0); release_op();
    do_op(4'h4, 64'hBAD, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, 0); release_op();
    // Stall in HOLD, then back-to-back ops through the handshake edge
    do_op(4'h5, 64'd0, 64'h100, 64'd0, 5, 0);
    do_op(4'h6, rnd64(), 64'h55, rnd64(), 0, 1);
    do_op(4'h4, 64'h0123_4567, 64'h108, 64'd0, 1, 1);
    do_op(4'h5, 64'd0, 64'h108, 64'd0, 0, 1);
    release_op();
    do_op(4'h6, rnd64(), 64'h55, rnd64(), 0, 0); release_op();

    // Reset during WAIT abandons the store
    do_op(4'h4, 64'h0BAD_F00D, 64'h80, 64'd0, 0, 0); release_op();
    icode = 4'h4; val_a = 64'hFFFF_0000_FFFF_0000; val_e = 64'h80; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", o_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_cleared("rst_wait");
    do_op(4'h5, 64'd0, 64'h80, 64'd0, 0, 0); release_op();

    // Truncating instance: latency 3, low bits ignored
    sel = 1; #1;
    do_op(4'h4, 64'h0FED_CBA9, 64'h100, 64'd0, 0, 0); release_op();
    do_op(4'h5, 64'd0, 64'h103, 64'd0, 0, 0); release_op();
    do_op(4'h5, 64'd0, 64'h2000, 64'd0, 0, 0); release_op();
    do_op(4'h4, 64'h77, 64'h10F, 64'd0, 0, 0); release_op();
    do_op(4'h5, 64'd0, 64'h108, 64'd0, 0, 0); release_op();
    random_ops(30);

    sel = 0; #1;
    random_ops(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
